// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with branch resolution.
//
// Captures the EX-stage instruction into the MEM stage. It also resolves
// conditional branches and jumps into a one-cycle registered fetch redirect,
// and keeps saturating counts of resolved and taken conditional branches.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   stall_i, flush_i     hold all state / load a bubble (stall wins)
//   ex_*_i               EX-stage instruction, ALU result and flags, control
//   mem_*_o              registered MEM-stage copies of the EX fields
//   redirect_o           one-cycle pulse per captured taken branch/jump
//   redirect_pc_o        target of the most recent redirect
//   br_cnt_o             resolved conditional branches (saturating)
//   br_taken_cnt_o       taken conditional branches (saturating)
module ex_mem_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             ex_valid_i,
  input  logic [31:0]      ex_alu_c_i,
  input  logic             ex_zero_i,
  input  logic             ex_sign_i,
  input  logic             ex_ovf_i,
  input  logic             ex_carry_i,
  input  logic [2:0]       ex_br_type_i,
  input  logic             ex_jal_i,
  input  logic             ex_jalr_i,
  input  logic [31:0]      ex_pc_i,
  input  logic [31:0]      ex_imm_i,
  input  logic [31:0]      ex_rs2_data_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_memread_i,
  input  logic             ex_memwrite_i,
  input  logic [1:0]       ex_wdsel_i,
  input  logic [2:0]       ex_dm_type_i,
  output logic             mem_valid_o,
  output logic [31:0]      mem_alu_c_o,
  output logic [31:0]      mem_rs2_data_o,
  output logic [31:0]      mem_pc4_o,
  output logic [4:0]       mem_rd_o,
  output logic             mem_regwrite_o,
  output logic             mem_memread_o,
  output logic             mem_memwrite_o,
  output logic [1:0]       mem_wdsel_o,
  output logic [2:0]       mem_dm_type_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] br_taken_cnt_o
);

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic        is_branch;
  logic        cond;
  logic        is_jump;
  logic        taken;
  logic [31:0] target;
  logic        load;

  // EX-stage resolution (combinational, ahead of the p1 register)
  always_comb begin
    cond      = 1'b0;
    is_branch = 1'b1;
    case (ex_br_type_i)
      BR_BEQ:  cond = ex_zero_i;
      BR_BNE:  cond = ~ex_zero_i;
      BR_BLT:  cond = ex_sign_i ^ ex_ovf_i;
      BR_BGE:  cond = ~(ex_sign_i ^ ex_ovf_i);
      BR_BLTU: cond = ex_carry_i;
      BR_BGEU: cond = ~ex_carry_i;
      default: is_branch = 1'b0;  // none and reserved
    endcase
  end

  // A jump overrides any branch type carried alongside it.
  assign is_jump = ex_jal_i | ex_jalr_i;
  assign taken   = ex_valid_i & ((is_branch & cond) | is_jump);
  assign target  = ex_jalr_i ? {ex_alu_c_i[31:1], 1'b0} : ex_pc_i + ex_imm_i;
  assign load    = ~stall_i & ~flush_i;

  // MEM-stage register (p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_o    <= 1'b0;
      mem_alu_c_o    <= '0;
      mem_rs2_data_o <= '0;
      mem_pc4_o      <= '0;
      mem_rd_o       <= '0;
      mem_regwrite_o <= 1'b0;
      mem_memread_o  <= 1'b0;
      mem_memwrite_o <= 1'b0;
      mem_wdsel_o    <= '0;
      mem_dm_type_o  <= '0;
      redirect_o     <= 1'b0;
      redirect_pc_o  <= '0;
      br_cnt_o       <= '0;
      br_taken_cnt_o <= '0;
    end else if (stall_i) begin
      // Held instruction has already redirected once; do not repeat it.
      redirect_o <= 1'b0;
    end else if (flush_i) begin
      mem_valid_o    <= 1'b0;
      mem_regwrite_o <= 1'b0;
      mem_memread_o  <= 1'b0;
      mem_memwrite_o <= 1'b0;
      redirect_o     <= 1'b0;
    end else if (load) begin
      mem_valid_o    <= ex_valid_i;
      mem_alu_c_o    <= ex_alu_c_i;
      mem_rs2_data_o <= ex_rs2_data_i;
      mem_pc4_o      <= ex_pc_i + 32'd4;
      mem_rd_o       <= ex_rd_i;
      mem_regwrite_o <= ex_valid_i & ex_regwrite_i;
      mem_memread_o  <= ex_valid_i & ex_memread_i;
      mem_memwrite_o <= ex_valid_i & ex_memwrite_i;
      mem_wdsel_o    <= ex_wdsel_i;
      mem_dm_type_o  <= ex_dm_type_i;
      redirect_o     <= taken;
      if (taken) redirect_pc_o <= target;
      if (ex_valid_i && is_branch) begin
        br_cnt_o <= sat_inc(br_cnt_o);
        if (cond) br_taken_cnt_o <= sat_inc(br_taken_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed self-checking bench for ex_mem_reg.
// Two instances share the stimulus: default CNT_W and CNT_W=4 for saturation.
module tb_ex_mem_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_i, flush_i, ex_valid_i;
  logic [31:0] ex_alu_c_i;
  logic        ex_zero_i, ex_sign_i, ex_ovf_i, ex_carry_i;
  logic [2:0]  ex_br_type_i;
  logic        ex_jal_i, ex_jalr_i;
  logic [31:0] ex_pc_i, ex_imm_i, ex_rs2_data_i;
  logic [4:0]  ex_rd_i;
  logic        ex_regwrite_i, ex_memread_i, ex_memwrite_i;
  logic [1:0]  ex_wdsel_i;
  logic [2:0]  ex_dm_type_i;

  logic        mem_valid_o, mem_regwrite_o, mem_memread_o, mem_memwrite_o, redirect_o;
  logic [31:0] mem_alu_c_o, mem_rs2_data_o, mem_pc4_o, redirect_pc_o;
  logic [4:0]  mem_rd_o;
  logic [1:0]  mem_wdsel_o;
  logic [2:0]  mem_dm_type_o;
  logic [15:0] br_cnt_o, br_taken_cnt_o;

  logic        s_valid, s_regwrite, s_memread, s_memwrite, s_redirect;
  logic [31:0] s_alu_c, s_rs2_data, s_pc4, s_redirect_pc;
  logic [4:0]  s_rd;
  logic [1:0]  s_wdsel;
  logic [2:0]  s_dm_type;
  logic [3:0]  s_br_cnt, s_br_taken_cnt;

  int checks = 0;
  int errors = 0;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_alu_c_i(ex_alu_c_i), .ex_zero_i(ex_zero_i),
    .ex_sign_i(ex_sign_i), .ex_ovf_i(ex_ovf_i), .ex_carry_i(ex_carry_i),
    .ex_br_type_i(ex_br_type_i), .ex_jal_i(ex_jal_i), .ex_jalr_i(ex_jalr_i),
    .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i), .ex_rs2_data_i(ex_rs2_data_i),
    .ex_rd_i(ex_rd_i), .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i),
    .ex_memwrite_i(ex_memwrite_i), .ex_wdsel_i(ex_wdsel_i), .ex_dm_type_i(ex_dm_type_i),
    .mem_valid_o(mem_valid_o), .mem_alu_c_o(mem_alu_c_o), .mem_rs2_data_o(mem_rs2_data_o),
    .mem_pc4_o(mem_pc4_o), .mem_rd_o(mem_rd_o), .mem_regwrite_o(mem_regwrite_o),
    .mem_memread_o(mem_memread_o), .mem_memwrite_o(mem_memwrite_o),
    .mem_wdsel_o(mem_wdsel_o), .mem_dm_type_o(mem_dm_type_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .br_cnt_o(br_cnt_o), .br_taken_cnt_o(br_taken_cnt_o)
  );

  ex_mem_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_alu_c_i(ex_alu_c_i), .ex_zero_i(ex_zero_i),
    .ex_sign_i(ex_sign_i), .ex_ovf_i(ex_ovf_i), .ex_carry_i(ex_carry_i),
    .ex_br_type_i(ex_br_type_i), .ex_jal_i(ex_jal_i), .ex_jalr_i(ex_jalr_i),
    .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i), .ex_rs2_data_i(ex_rs2_data_i),
    .ex_rd_i(ex_rd_i), .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i),
    .ex_memwrite_i(ex_memwrite_i), .ex_wdsel_i(ex_wdsel_i), .ex_dm_type_i(ex_dm_type_i),
    .mem_valid_o(s_valid), .mem_alu_c_o(s_alu_c), .mem_rs2_data_o(s_rs2_data),
    .mem_pc4_o(s_pc4), .mem_rd_o(s_rd), .mem_regwrite_o(s_regwrite),
    .mem_memread_o(s_memread), .mem_memwrite_o(s_memwrite),
    .mem_wdsel_o(s_wdsel), .mem_dm_type_o(s_dm_type),
    .redirect_o(s_redirect), .redirect_pc_o(s_redirect_pc),
    .br_cnt_o(s_br_cnt), .br_taken_cnt_o(s_br_taken_cnt)
  );

  task automatic idle_ex();
    stall_i = 0; flush_i = 0; ex_valid_i = 0; ex_alu_c_i = 0;
    ex_zero_i = 0; ex_sign_i = 0; ex_ovf_i = 0; ex_carry_i = 0;
    ex_br_type_i = 0; ex_jal_i = 0; ex_jalr_i = 0;
    ex_pc_i = 0; ex_imm_i = 0; ex_rs2_data_i = 0; ex_rd_i = 0;
    ex_regwrite_i = 0; ex_memread_i = 0; ex_memwrite_i = 0;
    ex_wdsel_i = 0; ex_dm_type_i = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle_ex();
    ex_valid_i = 1; ex_jal_i = 1; ex_pc_i = 32'h1000; ex_imm_i = 32'h40;
    ex_regwrite_i = 1; ex_alu_c_i = 32'hDEAD; stall_i = 1; flush_i = 1;
    rst = 1; tick(); rst = 0;
    checks++; if ({mem_valid_o, mem_regwrite_o, mem_memread_o, mem_memwrite_o, redirect_o} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 00000", {mem_valid_o, mem_regwrite_o, mem_memread_o, mem_memwrite_o, redirect_o}); end
    checks++; if ({mem_alu_c_o, mem_rs2_data_o, mem_pc4_o, redirect_pc_o} !== 128'b0) begin errors++; $display("FAIL reset_data got %h %h %h %h exp 0", mem_alu_c_o, mem_rs2_data_o, mem_pc4_o, redirect_pc_o); end
    checks++; if ({mem_rd_o, mem_wdsel_o, mem_dm_type_o, br_cnt_o, br_taken_cnt_o} !== 42'b0) begin errors++; $display("FAIL reset_misc got rd %h cnt %0d/%0d exp 0", mem_rd_o, br_cnt_o, br_taken_cnt_o); end
    idle_ex();
  endtask

  task automatic test_blt();
    idle_ex();
    ex_valid_i = 1; ex_br_type_i = 3'd3; ex_alu_c_i = 32'hFFFF_FFF8; ex_sign_i = 1;
    ex_pc_i = 32'h100; ex_imm_i = 32'h20; ex_rs2_data_i = 32'h3;
    tick();
    checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL blt_redirect got %b exp 1", redirect_o); end
    checks++; if (redirect_pc_o !== 32'h120) begin errors++; $display("FAIL blt_target got %h exp 00000120", redirect_pc_o); end
    checks++; if (br_cnt_o !== 16'd1 || br_taken_cnt_o !== 16'd1) begin errors++; $display("FAIL blt_cnt got %0d/%0d exp 1/1", br_cnt_o, br_taken_cnt_o); end
    checks++; if (mem_valid_o !== 1'b1 || mem_alu_c_o !== 32'hFFFF_FFF8 || mem_pc4_o !== 32'h104 || mem_rs2_data_o !== 32'h3) begin errors++; $display("FAIL blt_fields got v%b c %h pc4 %h rs2 %h exp 1 fffffff8 104 3", mem_valid_o, mem_alu_c_o, mem_pc4_o, mem_rs2_data_o); end
    // invalid slot with control bits set: bubble-like, data fields load
    idle_ex();
    ex_regwrite_i = 1; ex_memread_i = 1; ex_memwrite_i = 1; ex_jal_i = 1;
    ex_rd_i = 5'd9; ex_alu_c_i = 32'h77; ex_pc_i = 32'h500;
    tick();
    checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h120) begin errors++; $display("FAIL blt_after got %b %h exp 0 00000120", redirect_o, redirect_pc_o); end
    checks++; if ({mem_valid_o, mem_regwrite_o, mem_memread_o, mem_memwrite_o} !== 4'b0) begin errors++; $display("FAIL invalid_ctrl got %b exp 0000", {mem_valid_o, mem_regwrite_o, mem_memread_o, mem_memwrite_o}); end
    checks++; if (mem_rd_o !== 5'd9 || mem_alu_c_o !== 32'h77 || mem_pc4_o !== 32'h504) begin errors++; $display("FAIL invalid_data got %0d %h %h exp 9 77 504", mem_rd_o, mem_alu_c_o, mem_pc4_o); end
    checks++; if (br_cnt_o !== 16'd1) begin errors++; $display("FAIL invalid_cnt got %0d exp 1", br_cnt_o); end
  endtask

  task automatic test_bgeu();
    idle_ex();
    ex_valid_i = 1; ex_br_type_i = 3'd6; ex_carry_i = 1; ex_pc_i = 32'h200; ex_imm_i = 32'h8;
    tick();
    checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h120) begin errors++; $display("FAIL bgeu_redirect got %b %h exp 0 00000120", redirect_o, redirect_pc_o); end
    checks++; if (br_cnt_o !== 16'd2 || br_taken_cnt_o !== 16'd1) begin errors++; $display("FAIL bgeu_cnt got %0d/%0d exp 2/1", br_cnt_o, br_taken_cnt_o); end
  endtask

  task automatic test_jalr();
    idle_ex();
    ex_valid_i = 1; ex_jalr_i = 1; ex_alu_c_i = 32'h0000_1235; ex_pc_i = 32'h40;
    ex_imm_i = 32'h999; ex_regwrite_i = 1; ex_rd_i = 5'd1; ex_wdsel_i = 2'd2;
    tick();
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0000_1234) begin errors++; $display("FAIL jalr_target got %b %h exp 1 00001234", redirect_o, redirect_pc_o); end
    checks++; if (mem_pc4_o !== 32'h44 || mem_regwrite_o !== 1'b1 || mem_wdsel_o !== 2'd2) begin errors++; $display("FAIL jalr_fields got %h %b %0d exp 44 1 2", mem_pc4_o, mem_regwrite_o, mem_wdsel_o); end
    checks++; if (br_cnt_o !== 16'd2 || br_taken_cnt_o !== 16'd1) begin errors++; $display("FAIL jalr_cnt got %0d/%0d exp 2/1", br_cnt_o, br_taken_cnt_o); end
  endtask

  task automatic test_jal_with_branch();
    // BEQ with Zero=0 plus JAL: resolved as jump, branch still counted not-taken
    idle_ex();
    ex_valid_i = 1; ex_jal_i = 1; ex_br_type_i = 3'd1; ex_pc_i = 32'h200; ex_imm_i = 32'h10;
    ex_alu_c_i = 32'hABCD_0001;
    tick();
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h210) begin errors++; $display("FAIL jalbr_target got %b %h exp 1 00000210", redirect_o, redirect_pc_o); end
    checks++; if (br_cnt_o !== 16'd3 || br_taken_cnt_o !== 16'd1) begin errors++; $display("FAIL jalbr_cnt got %0d/%0d exp 3/1", br_cnt_o, br_taken_cnt_o); end
    // reserved type 7: no redirect, not counted
    idle_ex();
    ex_valid_i = 1; ex_br_type_i = 3'd7; ex_zero_i = 1; ex_carry_i = 1; ex_pc_i = 32'h300;
    tick();
    checks++; if (redirect_o !== 1'b0 || br_cnt_o !== 16'd3 || br_taken_cnt_o !== 16'd1) begin errors++; $display("FAIL reserved got %b %0d/%0d exp 0 3/1", redirect_o, br_cnt_o, br_taken_cnt_o); end
  endtask

  task automatic test_stall_flush();
    idle_ex(); do_reset();
    ex_valid_i = 1; ex_alu_c_i = 32'h55; ex_rs2_data_i = 32'hAA; ex_pc_i = 32'h300;
    ex_rd_i = 5'd5; ex_regwrite_i = 1; ex_wdsel_i = 2'd1; ex_dm_type_i = 3'd2;
    tick();
    checks++; if (mem_valid_o !== 1'b1 || mem_rd_o !== 5'd5 || mem_regwrite_o !== 1'b1 || mem_alu_c_o !== 32'h55) begin errors++; $display("FAIL add_capture got %b %0d %b %h exp 1 5 1 55", mem_valid_o, mem_rd_o, mem_regwrite_o, mem_alu_c_o); end
    idle_ex();
    stall_i = 1; flush_i = 1; ex_valid_i = 1; ex_br_type_i = 3'd1; ex_zero_i = 1;
    ex_pc_i = 32'h600; ex_imm_i = 32'h4; ex_alu_c_i = 32'h99; ex_rd_i = 5'd7; ex_memwrite_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem_valid_o !== 1'b1 || mem_rd_o !== 5'd5 || mem_regwrite_o !== 1'b1 || mem_memwrite_o !== 1'b0 || mem_alu_c_o !== 32'h55 || mem_rs2_data_o !== 32'hAA || mem_pc4_o !== 32'h304 || mem_wdsel_o !== 2'd1 || mem_dm_type_o !== 3'd2) begin errors++; $display("FAIL stall_hold_%0d got v%b rd%0d rw%b mw%b c %h pc4 %h", i, mem_valid_o, mem_rd_o, mem_regwrite_o, mem_memwrite_o, mem_alu_c_o, mem_pc4_o); end
      checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0 || br_cnt_o !== 16'd0 || br_taken_cnt_o !== 16'd0) begin errors++; $display("FAIL stall_quiet_%0d got %b %h %0d/%0d exp 0 0 0/0", i, redirect_o, redirect_pc_o, br_cnt_o, br_taken_cnt_o); end
    end
    stall_i = 0;
    tick();
    checks++; if (mem_valid_o !== 1'b0 || mem_regwrite_o !== 1'b0 || mem_memwrite_o !== 1'b0 || redirect_o !== 1'b0) begin errors++; $display("FAIL flush_bubble got %b %b %b %b exp 0000", mem_valid_o, mem_regwrite_o, mem_memwrite_o, redirect_o); end
    checks++; if (br_cnt_o !== 16'd0 || br_taken_cnt_o !== 16'd0 || redirect_pc_o !== 32'h0) begin errors++; $display("FAIL flush_cnt got %0d/%0d %h exp 0/0 0", br_cnt_o, br_taken_cnt_o, redirect_pc_o); end
    idle_ex();
  endtask

  task automatic test_stall_redirect();
    // taken branch then stall: the redirect must pulse only once
    idle_ex();
    ex_valid_i = 1; ex_br_type_i = 3'd4; ex_pc_i = 32'h1000; ex_imm_i = 32'hFFFF_FFF0;
    tick();
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0FF0) begin errors++; $display("FAIL bge_back got %b %h exp 1 00000ff0", redirect_o, redirect_pc_o); end
    stall_i = 1;
    tick();
    checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0FF0 || mem_valid_o !== 1'b1 || br_cnt_o !== 16'd1) begin errors++; $display("FAIL stall_pulse got %b %h %b %0d exp 0 00000ff0 1 1", redirect_o, redirect_pc_o, mem_valid_o, br_cnt_o); end
    idle_ex();
  endtask

  task automatic test_rst_stall();
    idle_ex();
    ex_valid_i = 1; ex_br_type_i = 3'd2; ex_zero_i = 0; ex_pc_i = 32'h80; ex_imm_i = 32'h8;
    ex_regwrite_i = 1; ex_rd_i = 5'd3;
    tick();
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h88) begin errors++; $display("FAIL bne_taken got %b %h exp 1 00000088", redirect_o, redirect_pc_o); end
    rst = 1; stall_i = 1;
    tick();
    rst = 0;
    checks++; if ({mem_valid_o, mem_regwrite_o, redirect_o} !== 3'b0 || redirect_pc_o !== 32'h0 || mem_pc4_o !== 32'h0 || mem_rd_o !== 5'd0 || br_cnt_o !== 16'd0 || br_taken_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_stall got v%b r%b pc %h pc4 %h cnt %0d", mem_valid_o, redirect_o, redirect_pc_o, mem_pc4_o, br_cnt_o); end
    idle_ex();
    stall_i = 1; tick();
    stall_i = 0; tick();
    checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0 || mem_valid_o !== 1'b0 || br_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_after got %b %h %b %0d exp 0 0 0 0", redirect_o, redirect_pc_o, mem_valid_o, br_cnt_o); end
  endtask

  task automatic test_saturate();
    idle_ex(); do_reset();
    ex_valid_i = 1; ex_br_type_i = 3'd1; ex_zero_i = 1; ex_pc_i = 32'h10; ex_imm_i = 32'h4;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (s_br_cnt !== 4'd15 || s_br_taken_cnt !== 4'd15) begin errors++; $display("FAIL sat4 got %0d/%0d exp 15/15", s_br_cnt, s_br_taken_cnt); end
    checks++; if (br_cnt_o !== 16'd20 || br_taken_cnt_o !== 16'd20) begin errors++; $display("FAIL cnt16 got %0d/%0d exp 20/20", br_cnt_o, br_taken_cnt_o); end
    checks++; if (s_redirect !== 1'b1 || s_redirect_pc !== 32'h14) begin errors++; $display("FAIL sat4_redirect got %b %h exp 1 00000014", s_redirect, s_redirect_pc); end
    idle_ex();
  endtask

  initial begin
    idle_ex();
    rst = 1;
    tick();
    test_reset();
    test_blt();
    test_bgeu();
    test_jalr();
    test_jal_with_branch();
    test_stall_flush();
    test_stall_redirect();
    test_rst_stall();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the branch statistics counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall_i  input  1  hold all state this cycle.
REQ-005 SHALL have port flush_i  input  1  load a bubble instead of the EX instruction.
REQ-006 SHALL have port ex_valid_i  input  1  EX slot holds a real instruction.
REQ-007 SHALL have ports ex_alu_c_i  input  32, and ex_zero_i, ex_sign_i, ex_ovf_i, ex_carry_i  input  1 each: ALU result C and flags Zero, Sign, Overflow, Carry.
REQ-008 SHALL have port ex_br_type_i  input  3  branch type: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 reserved (treated as none).
REQ-009 SHALL have ports ex_jal_i, ex_jalr_i  input  1 each  unconditional jump kinds.
REQ-010 SHALL have ports ex_pc_i, ex_imm_i, ex_rs2_data_i  input  32 each  instruction PC, immediate, store data.
REQ-011 SHALL have ports ex_rd_i  input  5; ex_regwrite_i, ex_memread_i, ex_memwrite_i  input  1; ex_wdsel_i  input  2; ex_dm_type_i  input  3: writeback/memory control.
REQ-012 SHALL have outputs mem_valid_o 1, mem_alu_c_o 32, mem_rs2_data_o 32, mem_pc4_o 32, mem_rd_o 5, mem_regwrite_o 1, mem_memread_o 1, mem_memwrite_o 1, mem_wdsel_o 2, mem_dm_type_o 3: registered MEM-stage copies.
REQ-013 SHALL have outputs redirect_o  1  and redirect_pc_o  32: registered fetch redirect.
REQ-014 SHALL have outputs br_cnt_o, br_taken_cnt_o  CNT_W each: resolved and taken conditional branch counts.

Function
REQ-015 SHALL evaluate, combinationally, the condition: BEQ Zero; BNE !Zero; BLT Sign^Overflow; BGE !(Sign^Overflow); BLTU Carry; BGEU !Carry.
REQ-016 SHALL define taken = ex_valid_i & (condition for types 1-6 | ex_jal_i | ex_jalr_i).
REQ-017 SHALL compute target = ex_pc_i + ex_imm_i (mod 2^32) for branches/JAL, and ex_alu_c_i with bit 0 cleared for JALR.
REQ-018 SHALL apply update priority per edge: rst > stall_i > flush_i > normal load.
REQ-019 On normal load SHALL register all ex_* fields into the mem_* outputs with 1-cycle latency, mem_valid_o = ex_valid_i, and mem_pc4_o = ex_pc_i + 4.
REQ-020 On normal load SHALL set redirect_o = taken and redirect_pc_o = target when taken, else redirect_pc_o holds its previous value.
REQ-021 When ex_valid_i = 0 on load SHALL force mem_regwrite_o, mem_memread_o, mem_memwrite_o, redirect_o to 0; data fields load as presented.
REQ-022 On flush_i (no stall) SHALL set mem_valid_o, mem_regwrite_o, mem_memread_o, mem_memwrite_o, redirect_o to 0; other fields don't-care but deterministic (hold).
REQ-023 On stall_i SHALL hold every mem_* output and redirect_pc_o, and SHALL drive redirect_o to 0, so a redirect pulses exactly one cycle per captured instruction.
REQ-024 SHALL increment br_cnt_o on each normal load with ex_valid_i = 1 and ex_br_type_i in 1-6; br_taken_cnt_o additionally when the condition holds.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 and never wrap; jumps SHALL not be counted.
REQ-026 flush_i and stall_i SHALL not increment counters.
REQ-027 ex_br_type_i in 1-6 together with ex_jal_i/ex_jalr_i SHALL be resolved as the jump (taken, jump target); only the branch counter rule of REQ-024 still applies.

Reset
REQ-028 With rst high at an edge, all outputs SHALL become 0 (mem_pc4_o, redirect_pc_o, counters included), overriding stall_i and flush_i.
REQ-029 Reset mid-stall or mid-redirect SHALL drop the held instruction and any pending redirect pulse with no later effect.

Verification
REQ-030 BLT, A=-5, B=3 (ALU: C=0xFFFFFFF8, Sign=1, Ovf=0), pc=0x100, imm=0x20 -> next cycle redirect_o=1, redirect_pc_o=0x120, br_cnt=1, br_taken_cnt=1; following cycle redirect_o=0.
REQ-031 BGEU, A=1, B=0xFFFFFFFF (Carry=1) -> redirect_o=0, br_cnt increments, br_taken_cnt unchanged.
REQ-032 JALR, alu_c=0x00001235, pc=0x40 -> redirect_pc_o=0x00001234, mem_pc4_o=0x44, counters unchanged.
REQ-033 Captured ADD rd=5 regwrite=1, then stall 3 cycles with new EX data and flush_i=1 -> outputs unchanged all 3 cycles; release with flush_i=1 -> mem_valid_o=0, mem_regwrite_o=0.
REQ-034 CNT_W=4, 20 taken BEQ loads -> br_cnt_o and br_taken_cnt_o stop at 15.
REQ-035 Taken BNE captured, rst asserted the next edge alongside stall_i=1 -> all outputs 0, no redirect afterwards.
